// File: rtl/ddr_app_responder.sv
// RAM-backed stand-in for a DDR controller user-application interface.
// Buffers commands and write beats and executes two-beat bursts in order.
module ddr_app_responder #(
    parameter int unsigned MEM_ADDR_BITS  = 12,
    parameter int unsigned CALIB_CYCLES   = 64,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned WDF_DEPTH      = 8,
    parameter int unsigned READ_LATENCY   = 6,
    parameter int unsigned REFRESH_PERIOD = 256,
    parameter int unsigned REFRESH_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        init_calib_complete,
    input  logic [26:0] app_addr,
    input  logic [2:0]  app_cmd,
    input  logic        app_en,
    output logic        app_rdy,
    input  logic [63:0] app_wdf_data,
    input  logic [7:0]  app_wdf_mask,
    input  logic        app_wdf_wren,
    input  logic        app_wdf_end,
    output logic        app_wdf_rdy,
    output logic [63:0] app_rd_data,
    output logic        app_rd_data_valid,
    output logic        app_rd_data_end,
    output logic        protocol_error_o
);
    localparam int unsigned BurstW = MEM_ADDR_BITS - 1;
    localparam int unsigned CmdAw  = $clog2(CMD_DEPTH);
    localparam int unsigned WdfAw  = $clog2(WDF_DEPTH);
    localparam int unsigned CalW   = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned LatW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {StIdle, StWr0, StWr1, StRdWait, StRd0, StRd1} state_e;

    state_e                   state_q;
    logic [CalW-1:0]          cal_cnt_q;
    logic [31:0]              ref_cnt_q;
    logic                     refresh_active;
    logic [BurstW-1:0]        cur_addr_q;
    logic [LatW-1:0]          lat_cnt_q;

    logic [BurstW:0]          cmd_mem [CMD_DEPTH];
    logic [CmdAw-1:0]         cmd_wptr_q, cmd_rptr_q;
    logic [CmdAw:0]           cmd_cnt_q;
    logic                     cmd_full, cmd_empty, cmd_take, cmd_illegal, cmd_push, cmd_pop;
    logic [BurstW:0]          cmd_head;

    logic [72:0]              wdf_mem [WDF_DEPTH];
    logic [WdfAw-1:0]         wdf_wptr_q, wdf_rptr_q;
    logic [WdfAw:0]           wdf_cnt_q;
    logic                     wdf_full, wdf_empty, wdf_push, wdf_pop;
    logic [72:0]              wdf_head;

    logic [63:0]              mem [2**MEM_ADDR_BITS];
    logic [63:0]              ram_q;
    logic                     rd_beat;
    logic [MEM_ADDR_BITS-1:0] rd_idx, wr_idx;

    // Address bits outside the backing store alias; low bits are burst-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{app_addr[26:MEM_ADDR_BITS+2], app_addr[2:0]};

    assign refresh_active = (REFRESH_PERIOD != 0) &&
                            (ref_cnt_q >= REFRESH_PERIOD - REFRESH_CYCLES);

    assign cmd_full    = (cmd_cnt_q == (CmdAw+1)'(CMD_DEPTH));
    assign cmd_empty   = (cmd_cnt_q == '0);
    assign app_rdy     = init_calib_complete && !cmd_full && !refresh_active;
    assign cmd_take    = app_en && app_rdy;
    assign cmd_illegal = (app_cmd[2:1] != 2'b00);
    assign cmd_push    = cmd_take && !cmd_illegal;
    assign cmd_pop     = (state_q == StIdle) && !cmd_empty && !refresh_active;
    assign cmd_head    = cmd_mem[cmd_rptr_q];

    assign wdf_full    = (wdf_cnt_q == (WdfAw+1)'(WDF_DEPTH));
    assign wdf_empty   = (wdf_cnt_q == '0);
    assign app_wdf_rdy = init_calib_complete && !wdf_full;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;
    assign wdf_pop     = ((state_q == StWr0) || (state_q == StWr1)) && !wdf_empty;
    assign wdf_head    = wdf_mem[wdf_rptr_q];

    // RAM read is issued one cycle ahead of the beat it feeds.
    always_comb begin
        rd_beat = (state_q == StRdWait) && (lat_cnt_q == '0);
        rd_idx  = (state_q == StIdle) ? {cmd_head[BurstW-1:0], 1'b0} : {cur_addr_q, rd_beat};
        wr_idx  = {cur_addr_q, state_q == StWr1};
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) cmd_mem[cmd_wptr_q] <= {app_cmd[0], app_addr[MEM_ADDR_BITS+1:3]};
        if (wdf_push) wdf_mem[wdf_wptr_q] <= {app_wdf_data, app_wdf_mask, app_wdf_end};
        if (wdf_pop) begin
            for (int b = 0; b < 8; b++) begin
                if (!wdf_head[1+b]) mem[wr_idx][b*8 +: 8] <= wdf_head[9+b*8 +: 8];
            end
        end
        ram_q <= mem[rd_idx];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cal_cnt_q           <= '0;
            init_calib_complete <= 1'b0;
            ref_cnt_q           <= '0;
            cmd_wptr_q          <= '0;
            cmd_rptr_q          <= '0;
            cmd_cnt_q           <= '0;
            wdf_wptr_q          <= '0;
            wdf_rptr_q          <= '0;
            wdf_cnt_q           <= '0;
        end else begin
            if (!init_calib_complete) begin
                cal_cnt_q <= cal_cnt_q + 1'b1;
                if (cal_cnt_q == CalW'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
            end
            if (REFRESH_PERIOD != 0) begin
                ref_cnt_q <= (ref_cnt_q == REFRESH_PERIOD - 1) ? '0 : ref_cnt_q + 32'd1;
            end
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
            if (cmd_push && !cmd_pop)      cmd_cnt_q <= cmd_cnt_q + 1'b1;
            else if (!cmd_push && cmd_pop) cmd_cnt_q <= cmd_cnt_q - 1'b1;
            if (wdf_push) wdf_wptr_q <= wdf_wptr_q + 1'b1;
            if (wdf_pop)  wdf_rptr_q <= wdf_rptr_q + 1'b1;
            if (wdf_push && !wdf_pop)      wdf_cnt_q <= wdf_cnt_q + 1'b1;
            else if (!wdf_push && wdf_pop) wdf_cnt_q <= wdf_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q           <= StIdle;
            cur_addr_q        <= '0;
            lat_cnt_q         <= '0;
            app_rd_data       <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data_end   <= 1'b0;
            protocol_error_o  <= 1'b0;
        end else begin
            if (cmd_take && cmd_illegal) protocol_error_o <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (cmd_pop) begin
                        cur_addr_q <= cmd_head[BurstW-1:0];
                        if (cmd_head[BurstW]) begin
                            state_q   <= StRdWait;
                            lat_cnt_q <= LatW'(READ_LATENCY - 1);
                        end else begin
                            state_q <= StWr0;
                        end
                    end
                end
                StWr0: begin
                    if (!wdf_empty) begin
                        state_q <= StWr1;
                        if (wdf_head[0]) protocol_error_o <= 1'b1;
                    end
                end
                StWr1: begin
                    if (!wdf_empty) begin
                        state_q <= StIdle;
                        if (!wdf_head[0]) protocol_error_o <= 1'b1;
                    end
                end
                StRdWait: begin
                    if (lat_cnt_q == '0) begin
                        state_q           <= StRd0;
                        app_rd_data       <= ram_q;
                        app_rd_data_valid <= 1'b1;
                        app_rd_data_end   <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                StRd0: begin
                    state_q           <= StRd1;
                    app_rd_data       <= ram_q;
                    app_rd_data_valid <= 1'b1;
                    app_rd_data_end   <= 1'b1;
                end
                StRd1: begin
                    state_q           <= StIdle;
                    app_rd_data_valid <= 1'b0;
                    app_rd_data_end   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_app_responder.sv
// Scoreboard bench for ddr_app_responder: expected read beats are queued from a
// byte-masked memory model when reads are issued and compared as beats emerge.
`timescale 1ns/1ps
module tb_ddr_app_responder;
    localparam int unsigned CmdDepth = 4;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_calib_complete;
    logic [26:0] app_addr;
    logic [2:0]  app_cmd;
    logic        app_en;
    logic        app_rdy;
    logic [63:0] app_wdf_data;
    logic [7:0]  app_wdf_mask;
    logic        app_wdf_wren;
    logic        app_wdf_end;
    logic        app_wdf_rdy;
    logic [63:0] app_rd_data;
    logic        app_rd_data_valid;
    logic        app_rd_data_end;
    logic        protocol_error;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc;
    int          last_acc;
    logic [63:0] model_mem [4096];
    rd_exp_t     exp_q [$];

    ddr_app_responder #(
        .MEM_ADDR_BITS (12),
        .CALIB_CYCLES  (64),
        .CMD_DEPTH     (CmdDepth),
        .WDF_DEPTH     (8),
        .READ_LATENCY  (6),
        .REFRESH_PERIOD(32),
        .REFRESH_CYCLES(8)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .init_calib_complete(init_calib_complete),
        .app_addr           (app_addr),
        .app_cmd            (app_cmd),
        .app_en             (app_en),
        .app_rdy            (app_rdy),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_mask       (app_wdf_mask),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_rd_data        (app_rd_data),
        .app_rd_data_valid  (app_rd_data_valid),
        .app_rd_data_end    (app_rd_data_end),
        .protocol_error_o   (protocol_error)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the DUT refresh phase modulo 32.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && app_rd_data_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", app_rd_data_valid, 1'b0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check("rd_data", app_rd_data, e.data);
                check("rd_end", app_rd_data_end, e.last);
            end
        end else if (rst_n) begin
            check("rd_end_idle", app_rd_data_end, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && init_calib_complete && (cyc % 32) >= 24) check("rdy_refresh", app_rdy, 1'b0);
    end

    function automatic int unsigned widx(input logic [26:0] a, input logic b);
        return {a[13:3], b};
    endfunction

    task automatic model_write(input logic [26:0] a, input logic b, input logic [63:0] d,
                               input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (!m[i]) model_mem[widx(a, b)][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [26:0] a);
        int g = 0;
        app_cmd  = cmd;
        app_addr = a;
        app_en   = 1'b1;
        while (!app_rdy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("cmd_timeout", g >= 200, 1'b0);
        @(negedge clk);
        app_en   = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] m, input logic e);
        int g = 0;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end  = e;
        app_wdf_wren = 1'b1;
        while (!app_wdf_rdy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("wdf_timeout", g >= 200, 1'b0);
        @(negedge clk);
        app_wdf_wren = 1'b0;
    endtask

    task automatic do_write(input logic [26:0] a, input logic [63:0] d0, input logic [7:0] m0,
                            input logic e0, input logic [63:0] d1, input logic [7:0] m1,
                            input logic e1);
        model_write(a, 1'b0, d0, m0);
        model_write(a, 1'b1, d1, m1);
        send_cmd(3'b000, a);
        send_beat(d0, m0, e0);
        send_beat(d1, m1, e1);
    endtask

    task automatic do_read(input logic [26:0] a);
        rd_exp_t e;
        e.data = model_mem[widx(a, 1'b0)];
        e.last = 1'b0;
        exp_q.push_back(e);
        e.data = model_mem[widx(a, 1'b1)];
        e.last = 1'b1;
        exp_q.push_back(e);
        send_cmd(3'b001, a);
    endtask

    task automatic wait_refresh_end();
        int g = 0;
        while (app_rdy && g < 100) begin
            @(negedge clk);
            g++;
        end
        while (!app_rdy && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("refresh_wait_timeout", g >= 100, 1'b0);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("sb_drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_calib", init_calib_complete, 1'b0);
        check("rst_rdy", app_rdy, 1'b0);
        check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        check("rst_rd_data", app_rd_data, 64'h0);
        check("rst_rd_valid", app_rd_data_valid, 1'b0);
        check("rst_rd_end", app_rd_data_end, 1'b0);
        check("rst_perr", protocol_error, 1'b0);
    endtask

    task automatic wait_calib();
        int g = 0;
        while (!init_calib_complete && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("calib_timeout", g >= 200, 1'b0);
    endtask

    initial begin
        logic [26:0] fa [6];
        int          n_acc;
        int          g;
        rst_n        = 1'b0;
        app_addr     = '0;
        app_cmd      = '0;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Calibration window: low through cycle 63, high from 64.
        for (int i = 0; i < 67; i++) begin
            check("calib", init_calib_complete, cyc >= 64);
            if (cyc < 64) begin
                check("rdy_precal", app_rdy, 1'b0);
                check("wdf_rdy_precal", app_wdf_rdy, 1'b0);
            end
            @(negedge clk);
        end

        // Write then read back with latency check.
        do_write(27'h10, {4{16'h1111}}, 8'h00, 1'b0, {4{16'h2222}}, 8'h00, 1'b1);
        repeat (16) @(negedge clk);
        wait_refresh_end();
        do_read(27'h10);
        g = 0;
        while (!app_rd_data_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("rd_lat_beat0", cyc - last_acc, 7);
        check("rd_beat0_end", app_rd_data_end, 1'b0);
        @(negedge clk);
        check("rd_beat1_valid", app_rd_data_valid, 1'b1);
        check("rd_beat1_end", app_rd_data_end, 1'b1);
        @(negedge clk);
        check("rd_after_burst", app_rd_data_valid, 1'b0);

        // Byte mask: lower four bytes of beat 0 keep the old all-ones data.
        do_write(27'h20, '1, 8'h00, 1'b0, '1, 8'h00, 1'b1);
        do_write(27'h20, 64'h0, 8'h0F, 1'b0, {4{16'h3333}}, 8'h00, 1'b1);
        do_read(27'h20);
        drain();

        // Idle refresh pattern: rdy low exactly in the last 8 of every 32 cycles.
        for (int i = 0; i < 64; i++) begin
            check("rdy_idle", app_rdy, (cyc % 32) < 24);
            @(negedge clk);
        end

        // Command FIFO fills: one burst executing plus CmdDepth buffered.
        for (int k = 0; k < 6; k++) fa[k] = 27'h40 + 27'(k * 8);
        wait_refresh_end();
        n_acc    = 0;
        g        = 0;
        app_cmd  = 3'b000;
        app_addr = fa[0];
        app_en   = 1'b1;
        while (n_acc < CmdDepth + 1 && g < 40) begin
            if (app_rdy) n_acc++;
            @(negedge clk);
            app_addr = fa[n_acc];
            g++;
        end
        check("cmd_acc_count", n_acc, CmdDepth + 1);
        for (int i = 0; i < 3; i++) begin
            check("cmd_full_rdy", app_rdy, 1'b0);
            @(negedge clk);
        end
        app_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            model_write(fa[k], 1'b0, {32'hA5A5_0000 + 32'(k), 32'h0BEE_F000}, 8'h00);
            model_write(fa[k], 1'b1, {32'h5A5A_0000 + 32'(k), 32'h0CAF_E000}, 8'h00);
            send_beat({32'hA5A5_0000 + 32'(k), 32'h0BEE_F000}, 8'h00, 1'b0);
            send_beat({32'h5A5A_0000 + 32'(k), 32'h0CAF_E000}, 8'h00, 1'b1);
        end
        g = 0;
        while (!app_rdy && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("cmd_rdy_recover", app_rdy, 1'b1);
        for (int k = 0; k < 5; k++) do_read(fa[k]);
        drain();

        // Continuous reads across refresh windows.
        for (int i = 0; i < 16; i++) do_read((i % 3 == 0) ? 27'h10 : fa[i % 5]);
        drain();

        // Bad end markers set the sticky error.
        check("perr_clean", protocol_error, 1'b0);
        do_write(27'h100, {4{16'hDEAD}}, 8'h00, 1'b1, {4{16'hBEEF}}, 8'h00, 1'b0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("perr_end_sticky", protocol_error, 1'b1);
            repeat (5) @(negedge clk);
        end

        // Reset with a read in flight drops it; RAM survives.
        do_read(27'h10);
        repeat (3) @(negedge clk);
        rst_n        = 1'b0;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        wait_calib();

        // Illegal command: accepted, discarded, flags error.
        send_cmd(3'b010, 27'h20);
        @(negedge clk);
        check("perr_illegal", protocol_error, 1'b1);
        do_read(27'h10);
        drain();
        check("perr_illegal_sticky", protocol_error, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end
endmodule
